// File: rtl/jtframe_mix4.sv
// Four-channel signed audio mixer: per-channel 4.4 gain, 16-bit saturated sum, clip flag.
// Two cen-qualified pipeline stages: gain multiply, then sum/scale/saturate.
module jtframe_mix4 #(
    parameter int unsigned W0 = 16,
    parameter int unsigned W1 = 16,
    parameter int unsigned W2 = 16,
    parameter int unsigned W3 = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic signed [W0-1:0] ch0,
    input  logic signed [W1-1:0] ch1,
    input  logic signed [W2-1:0] ch2,
    input  logic signed [W3-1:0] ch3,
    input  logic        [7:0]    gain0,
    input  logic        [7:0]    gain1,
    input  logic        [7:0]    gain2,
    input  logic        [7:0]    gain3,
    output logic signed [15:0]   mixed,
    output logic                 peak
);

    logic signed [15:0] aligned [4];
    logic        [7:0]  gain    [4];
    logic signed [24:0] prod_d  [4];
    logic signed [24:0] prod_q  [4];
    logic signed [26:0] sum;
    logic signed [26:0] scaled;
    logic signed [15:0] mixed_d, mixed_q;
    logic               peak_d, peak_q;

    // Left-justify each channel so full scale of any width becomes 16-bit full scale.
    always_comb begin
        aligned[0] = $signed(16'(ch0)) <<< (16 - W0);
        aligned[1] = $signed(16'(ch1)) <<< (16 - W1);
        aligned[2] = $signed(16'(ch2)) <<< (16 - W2);
        aligned[3] = $signed(16'(ch3)) <<< (16 - W3);
        gain[0]    = gain0;
        gain[1]    = gain1;
        gain[2]    = gain2;
        gain[3]    = gain3;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod_d[i] = 25'(aligned[i]) * 25'($signed({1'b0, gain[i]}));
        end
    end

    always_comb begin
        sum     = 27'(prod_q[0]) + 27'(prod_q[1]) + 27'(prod_q[2]) + 27'(prod_q[3]);
        scaled  = sum >>> 4;
        mixed_d = scaled[15:0];
        peak_d  = 1'b0;
        if (scaled > 27'sd32767) begin
            mixed_d = 16'h7FFF;
            peak_d  = 1'b1;
        end else if (scaled < -27'sd32768) begin
            mixed_d = 16'h8000;
            peak_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= '0;
            end
            mixed_q <= '0;
            peak_q  <= 1'b0;
        end else if (cen) begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= prod_d[i];
            end
            mixed_q <= mixed_d;
            peak_q  <= peak_d;
        end
    end

    assign mixed = mixed_q;
    assign peak  = peak_q;

endmodule

// File: tb/tb_jtframe_mix4.sv
// Directed-vector bench for jtframe_mix4; a second instance covers a 10-bit channel.
module tb_jtframe_mix4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cen;
    logic signed [15:0] ch0, ch1, ch2, ch3;
    logic        [7:0]  gain0, gain1, gain2, gain3;
    logic signed [15:0] mixed;
    logic               peak;
    logic signed [9:0]  ch1n;
    logic        [7:0]  gain1n;
    logic signed [15:0] mixed_n;
    logic               peak_n;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtframe_mix4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .ch0   (ch0),
        .ch1   (ch1),
        .ch2   (ch2),
        .ch3   (ch3),
        .gain0 (gain0),
        .gain1 (gain1),
        .gain2 (gain2),
        .gain3 (gain3),
        .mixed (mixed),
        .peak  (peak)
    );

    jtframe_mix4 #(.W1(10)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .ch0   (ch0),
        .ch1   (ch1n),
        .ch2   (ch2),
        .ch3   (ch3),
        .gain0 (gain0),
        .gain1 (gain1n),
        .gain2 (gain2),
        .gain3 (gain3),
        .mixed (mixed_n),
        .peak  (peak_n)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One cen pulse lasting a single clock; starts and ends on a falling edge.
    task automatic pulse(input int n);
        repeat (n) begin
            cen = 1'b1;
            @(negedge clk);
            cen = 1'b0;
        end
    endtask

    task automatic set_gains(input logic [7:0] g0, g1, g2, g3);
        gain0 = g0;
        gain1 = g1;
        gain2 = g2;
        gain3 = g3;
    endtask

    initial begin
        rst_n  = 1'b0;
        cen    = 1'b0;
        ch0    = 16'sh4000;
        ch1    = '0;
        ch2    = '0;
        ch3    = '0;
        ch1n   = '0;
        gain1n = 8'h00;
        set_gains(8'h10, 8'h00, 8'h00, 8'h00);

        // Reset holds outputs at zero even with cen toggling
        @(negedge clk);
        repeat (6) begin
            cen = ~cen;
            @(negedge clk);
        end
        cen = 1'b0;
        check_val("rst_mixed", mixed, 16'h0000);
        check_val("rst_peak", {15'b0, peak}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(2);
        check_val("post_rst_mixed", mixed, 16'h4000);
        check_val("post_rst_peak", {15'b0, peak}, 16'h0000);

        // Unity sum and two-pulse latency
        ch0 = 16'sd1000;
        ch1 = -16'sd300;
        set_gains(8'h10, 8'h10, 8'h10, 8'h10);
        pulse(1);
        check_val("lat_one_pulse", mixed, 16'h4000);
        pulse(1);
        check_val("unity_sum", mixed, 16'd700);

        // 10-bit channel alignment on the second instance
        set_gains(8'h00, 8'h00, 8'h00, 8'h00);
        ch1n   = 10'sd100;
        gain1n = 8'h10;
        pulse(2);
        check_val("align_unity", mixed_n, 16'd6400);
        gain1n = 8'h08;
        pulse(2);
        check_val("align_half", mixed_n, 16'd3200);

        // Positive clip, then recovery
        ch0 = 16'sh6000;
        ch1 = 16'sh6000;
        set_gains(8'h10, 8'h10, 8'h10, 8'h10);
        pulse(2);
        check_val("pos_clip", mixed, 16'h7FFF);
        check_val("pos_clip_peak", {15'b0, peak}, 16'h0001);
        ch1 = '0;
        pulse(2);
        check_val("pos_recover", mixed, 16'h6000);
        check_val("pos_recover_peak", {15'b0, peak}, 16'h0000);

        // Exact full scale does not clip; one more LSB does
        ch0 = 16'sh7FFF;
        pulse(2);
        check_val("fullscale", mixed, 16'h7FFF);
        check_val("fullscale_peak", {15'b0, peak}, 16'h0000);
        ch1 = 16'sd1;
        pulse(2);
        check_val("over_by_one_peak", {15'b0, peak}, 16'h0001);

        // Negative clip with gain 2, then -1 at minimum gain
        ch0 = 16'sh8000;
        ch1 = '0;
        set_gains(8'h20, 8'h00, 8'h00, 8'h00);
        pulse(2);
        check_val("neg_clip", mixed, 16'h8000);
        check_val("neg_clip_peak", {15'b0, peak}, 16'h0001);
        ch0 = -16'sd1;
        gain0 = 8'h01;
        pulse(2);
        check_val("neg_trunc", mixed, 16'hFFFF);
        check_val("neg_trunc_peak", {15'b0, peak}, 16'h0000);

        // Floor on the shift: -17/16 -> -2; max gain 256*255/16 = 4080
        ch0 = -16'sd17;
        pulse(2);
        check_val("floor_shift", mixed, 16'hFFFE);
        ch0 = 16'sd256;
        gain0 = 8'hFF;
        pulse(2);
        check_val("max_gain", mixed, 16'd4080);

        // cen gating
        ch0 = 16'sd1000;
        gain0 = 8'h10;
        pulse(2);
        check_val("cen_base", mixed, 16'd1000);
        ch0 = 16'sd2000;
        repeat (50) @(negedge clk);
        check_val("cen_hold", mixed, 16'd1000);
        pulse(1);
        check_val("cen_one", mixed, 16'd1000);
        pulse(1);
        check_val("cen_resume", mixed, 16'd2000);

        // Asynchronous reset mid-operation
        ch0 = 16'sh6000;
        ch1 = 16'sh6000;
        set_gains(8'h10, 8'h10, 8'h00, 8'h00);
        pulse(2);
        check_val("pre_async_peak", {15'b0, peak}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_mixed", mixed, 16'h0000);
        check_val("async_peak", {15'b0, peak}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        ch1 = '0;
        @(negedge clk);
        pulse(1);
        check_val("async_one_pulse", mixed, 16'h0000);
        pulse(1);
        check_val("async_recover", mixed, 16'h6000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_mix4.md
Name: jtframe_mix4

Overview:
- Four-channel signed audio mixer with a per-channel 8-bit gain, saturation to a 16-bit output, and a clip (peak) flag.
- Sits after the sound chips (FM, PSG and similar) in a core's sound path and feeds the frame audio output.
- All processing advances only on the clock-enable, so it runs at the sound sample rate.

Parameters:
- W0, 16, width of ch0 in bits (2..16).
- W1, 16, width of ch1 in bits (2..16).
- W2, 16, width of ch2 in bits (2..16).
- W3, 16, width of ch3 in bits (2..16).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  clock enable; pipeline registers update only when high.
- ch0  in  W0  signed two's-complement channel 0.
- ch1  in  W1  signed channel 1.
- ch2  in  W2  signed channel 2.
- ch3  in  W3  signed channel 3.
- gain0  in  8  unsigned gain for ch0, 4.4 fixed point (8'h10 = unity).
- gain1  in  8  gain for ch1, same format.
- gain2  in  8  gain for ch2, same format.
- gain3  in  8  gain for ch3, same format.
- mixed  out  16  signed saturated mix.
- peak  out  1  high when the current mixed value was clipped.

Behaviour:
- Reset: while rst_n is low, all pipeline registers, mixed and peak are 0, regardless of clk or cen.
- Alignment:
  - Each chN is sign-extended and left-shifted by (16−WN) to a 16-bit signed value, so full scale of any width maps to 16-bit full scale.
  - Example: a 10-bit input is shifted left by 6.
- Stage 1, on clk rising edge with cen=1:
  - pN = aligned_chN × {1'b0, gainN}.
  - Signed 16 × signed 9 multiply gives a 25-bit result, registered.
- Stage 2, on the next cen: sum = p0+p1+p2+p3, held in 27 bits so the addition never overflows.
- Scaling: scaled = sum >>> 4 (arithmetic shift) to remove the 4 fractional gain bits.
- Saturation:
  - If scaled > 32767: mixed = 16'h7FFF and peak = 1.
  - If scaled < −32768: mixed = 16'h8000 and peak = 1.
  - Otherwise mixed = scaled[15:0] and peak = 0.
  - mixed and peak are registered together in stage 2.
- Latency:
  - An input change appears on mixed after exactly 2 cen pulses.
  - With cen held low, outputs and internal registers hold their values.
- peak is not sticky. It follows each output sample and clears on the first non-clipped sample.
- Gain 0 mutes a channel. Gain 8'hFF is about ×15.94.
- Truncation: the right shift rounds toward −∞ (no rounding). For example, −1 × 8'h01 gives a sum of −1, then −1 after the shift.
- Reset mid-operation forces mixed=0 and peak=0 at once. After release, the first valid output appears after 2 cen pulses.

Test Plan:
- Reset: hold rst_n=0 with ch0=16'h4000, gain0=8'h10 and cen toggling -> mixed=0, peak=0. Release, apply 2 cen pulses -> mixed=16'h4000, peak=0.
- Unity sum: ch0=1000, ch1=−300, ch2=ch3=0, all gains 8'h10 -> mixed=700 after exactly 2 cen pulses. With one cen pulse, mixed is still the old value.
- Width alignment: W1=10, ch1=10'sd100, gain1=8'h10, other gains 0 -> mixed=6400. Repeat with gain1=8'h08 -> mixed=3200.
- Positive clip: ch0=ch1=16'h6000, gains 8'h10 -> mixed=16'h7FFF, peak=1. Then ch1=0 -> mixed=16'h6000, peak=0 two cen pulses later.
- Negative clip and gain: ch0=16'h8000, gain0=8'h20 -> mixed=16'h8000, peak=1. Then ch0=−1, gain0=8'h01 -> mixed=−1, peak=0.
- cen gating: change ch0 while cen=0 for 50 clocks -> mixed unchanged. Resume cen -> new value after 2 pulses.
